// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the multi-channel clock-gating controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {CH_OFF, CH_WAKE, CH_ON, CH_DRAIN} ch_state_e;

    localparam int unsigned MIN_WAKE_LAT = 1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_gate_cell.sv
// Latch-based glitch-free clock gate; the park level of gclk is chosen by parameter.
module clk_gate_cell #(
    parameter bit CLK_LO_WHEN_DISABLED = 1'b1
) (
    input  logic clk,
    input  logic en,
    output logic gclk
);

    logic en_lat;

    generate
        if (CLK_LO_WHEN_DISABLED) begin : g_park_lo
            // Latch closed while clk is high, so en changes after posedge cannot glitch.
            always_latch begin
                if (!clk) en_lat = en;
            end
            assign gclk = clk & en_lat;
        end else begin : g_park_hi
            always_latch begin
                if (clk) en_lat = en;
            end
            assign gclk = clk | ~en_lat;
        end
    endgenerate

endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller: idle shutdown, wake-up with settle time,
// and a one-pulse-per-request wake acknowledge.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int unsigned NR_CH                = 4,
    parameter int unsigned IDLE_W               = 8,
    parameter int unsigned WAKE_LAT             = 2,
    parameter bit          CLK_LO_WHEN_DISABLED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_enable,
    input  logic [IDLE_W-1:0] idle_limit,
    input  logic [NR_CH-1:0]  busy,
    input  logic [NR_CH-1:0]  force_on,
    input  logic [NR_CH-1:0]  wake_req,
    output logic [NR_CH-1:0]  wake_ack,
    output logic [NR_CH-1:0]  ch_on,
    output logic [NR_CH-1:0]  gclk
);

    localparam int unsigned WAKE_CYC = (WAKE_LAT < MIN_WAKE_LAT) ? MIN_WAKE_LAT : WAKE_LAT;
    localparam int unsigned WAKE_W   = cnt_width(WAKE_CYC);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYC - 1);

    logic limit_zero;
    assign limit_zero = (idle_limit == '0);

    generate
        for (genvar i = 0; i < NR_CH; i++) begin : g_ch
            ch_state_e         state_q, state_d;
            logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
            logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
            logic              en_q;
            logic              ack_q, ack_d;
            logic              req_done_q, req_done_d;
            logic              active;
            logic [IDLE_W:0]   idle_inc;
            logic [IDLE_W-1:0] idle_sat;
            logic              limit_hit;
            logic              ch_on_w;
            logic              gate_en;

            assign active    = busy[i] | force_on[i] | wake_req[i];
            assign idle_inc  = {1'b0, idle_cnt_q} + (IDLE_W + 1)'(1);
            assign idle_sat  = idle_inc[IDLE_W] ? idle_cnt_q : idle_inc[IDLE_W-1:0];
            // Compare at IDLE_W+1 bits so a saturated count still reaches any limit.
            assign limit_hit = !limit_zero && (idle_inc >= {1'b0, idle_limit});

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q    <= CH_ON;
                    idle_cnt_q <= '0;
                    wake_cnt_q <= '0;
                    en_q       <= 1'b1;
                    ack_q      <= 1'b0;
                    req_done_q <= 1'b0;
                end else begin
                    state_q    <= state_d;
                    idle_cnt_q <= idle_cnt_d;
                    wake_cnt_q <= wake_cnt_d;
                    en_q       <= (state_d != CH_OFF);
                    ack_q      <= ack_d;
                    req_done_q <= req_done_d;
                end
            end

            always_comb begin
                state_d    = state_q;
                idle_cnt_d = idle_cnt_q;
                wake_cnt_d = wake_cnt_q;
                unique case (state_q)
                    CH_ON: begin
                        if (active) begin
                            idle_cnt_d = '0;
                        end else begin
                            idle_cnt_d = idle_sat;
                            if (limit_hit) state_d = CH_DRAIN;
                        end
                    end
                    CH_DRAIN: begin
                        if (active) begin
                            state_d    = CH_ON;
                            idle_cnt_d = '0;
                        end else begin
                            state_d = CH_OFF;
                        end
                    end
                    CH_OFF: begin
                        if (active) begin
                            state_d    = CH_WAKE;
                            wake_cnt_d = '0;
                        end
                    end
                    CH_WAKE: begin
                        wake_cnt_d = wake_cnt_q + WAKE_W'(1);
                        if (wake_cnt_q == WAKE_LAST) begin
                            state_d    = CH_ON;
                            idle_cnt_d = '0;
                        end
                    end
                    default: state_d = CH_ON;
                endcase
                // One ack per request level: blocked by the previous ack and by req_done.
                ack_d      = (state_d == CH_ON) & wake_req[i] & ~req_done_q & ~ack_q;
                req_done_d = wake_req[i] & (req_done_q | ack_d);
            end

            always_comb begin
                ch_on_w = (state_q != CH_OFF);
            end

            assign ch_on[i]    = ch_on_w;
            assign wake_ack[i] = ack_q;
            assign gate_en     = en_q | scan_enable;

            clk_gate_cell #(
                .CLK_LO_WHEN_DISABLED(CLK_LO_WHEN_DISABLED)
            ) u_cell (
                .clk  (clk),
                .en   (gate_en),
                .gclk (gclk[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_clk_gate_ctrl;

    localparam int unsigned NR_CH    = 4;
    localparam int unsigned IDLE_W   = 8;
    localparam int unsigned WAKE_LAT = 2;
    localparam int          IDLE_MAX = (1 << IDLE_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              scan_enable = 1'b0;
    logic [IDLE_W-1:0] idle_limit = '0;
    logic [NR_CH-1:0]  busy = '0;
    logic [NR_CH-1:0]  force_on = '0;
    logic [NR_CH-1:0]  wake_req = '0;
    logic [NR_CH-1:0]  wake_ack;
    logic [NR_CH-1:0]  ch_on;
    logic [NR_CH-1:0]  gclk;

    always #5 clk = ~clk;

    clk_gate_ctrl #(
        .NR_CH                (NR_CH),
        .IDLE_W               (IDLE_W),
        .WAKE_LAT             (WAKE_LAT),
        .CLK_LO_WHEN_DISABLED (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_enable (scan_enable),
        .idle_limit  (idle_limit),
        .busy        (busy),
        .force_on    (force_on),
        .wake_req    (wake_req),
        .wake_ack    (wake_ack),
        .ch_on       (ch_on),
        .gclk        (gclk)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: clock awake or not, remaining settle cycles, idle run length,
    // one-cycle drain grace, and acknowledge bookkeeping.
    bit               m_awake  [NR_CH];
    int               m_wleft  [NR_CH];
    int               m_idle   [NR_CH];
    bit               m_drain  [NR_CH];
    bit               m_ack    [NR_CH];
    bit               m_acked  [NR_CH];
    logic [NR_CH-1:0] exp_gclk;

    always @(posedge clk or posedge rst) begin
        bit aw, dr, act, run_n, ack_n;
        int wl, id;
        if (rst) begin
            for (int c = 0; c < NR_CH; c++) begin
                m_awake[c] = 1'b1;
                m_wleft[c] = 0;
                m_idle[c]  = 0;
                m_drain[c] = 1'b0;
                m_ack[c]   = 1'b0;
                m_acked[c] = 1'b0;
            end
            exp_gclk = '1;
        end else begin
            for (int c = 0; c < NR_CH; c++) begin
                exp_gclk[c] = m_awake[c] | scan_enable;
                act = busy[c] | force_on[c] | wake_req[c];
                aw  = m_awake[c];
                wl  = m_wleft[c];
                id  = m_idle[c];
                dr  = m_drain[c];
                if (!aw) begin
                    if (act) begin
                        aw = 1'b1;
                        wl = WAKE_LAT;
                    end
                end else if (wl > 0) begin
                    wl--;
                    if (wl == 0) id = 0;
                end else if (dr) begin
                    dr = 1'b0;
                    if (act) id = 0;
                    else aw = 1'b0;
                end else if (act) begin
                    id = 0;
                end else begin
                    if (idle_limit != 0 && id + 1 >= int'(idle_limit)) dr = 1'b1;
                    if (id < IDLE_MAX) id++;
                end
                run_n = aw && (wl == 0) && !dr;
                ack_n = run_n && wake_req[c] && !m_acked[c] && !m_ack[c];
                m_acked[c] = wake_req[c] && (m_acked[c] || ack_n);
                m_ack[c]   = ack_n;
                m_awake[c] = aw;
                m_wleft[c] = wl;
                m_idle[c]  = id;
                m_drain[c] = dr;
            end
        end
    end

    // Low phase: registered outputs against the model, gclk parked low.
    always @(negedge clk) begin
        logic [NR_CH-1:0] eo, ea;
        #1;
        if (chk_en) begin
            for (int c = 0; c < NR_CH; c++) begin
                eo[c] = m_awake[c];
                ea[c] = m_ack[c];
            end
            check("ch_on", ch_on, eo);
            check("wake_ack", wake_ack, ea);
            check("gclk_low_phase", gclk, '0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) check("gclk_high_phase", gclk, exp_gclk);
    end

    logic [NR_CH-1:0] gclk_prev = '0;
    realtime          rise_t [NR_CH];

    always @(gclk) begin
        for (int c = 0; c < NR_CH; c++) begin
            if (gclk[c] && !gclk_prev[c]) begin
                rise_t[c] = $realtime;
            end else if (!gclk[c] && gclk_prev[c] && chk_en) begin
                check("gclk_pulse_width", 32'(($realtime - rise_t[c]) >= 5.0), 1);
            end
        end
        gclk_prev = gclk;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_limit = 8'd4;
        repeat (3) tick();
        check("reset_ch_on", ch_on, 4'hF);
        check("reset_ack", wake_ack, 0);
        chk_en = 1'b1;
        rst = 1'b0;

        // Auto-gating with idle_limit=4.
        repeat (3) tick();
        check("idle_still_on", ch_on, 4'hF);
        tick();
        check("drain_still_on", ch_on, 4'hF);
        tick();
        check("off_after_drain", ch_on, 4'h0);
        @(posedge clk);
        #2;
        check("gclk_parked", gclk, 4'h0);

        // Wake handshake on ch0.
        tick();
        wake_req[0] = 1'b1;
        tick();
        check("wake_ch_on_t1", 32'(ch_on[0]), 1);
        check("wake_no_ack_t1", 32'(wake_ack[0]), 0);
        tick();
        check("wake_no_ack_t2", 32'(wake_ack[0]), 0);
        tick();
        check("wake_ack_t3", 32'(wake_ack[0]), 1);
        repeat (3) begin
            tick();
            check("held_req_no_reack", 32'(wake_ack[0]), 0);
        end
        wake_req[0] = 1'b0;
        tick();
        check("dropped_req_no_ack", 32'(wake_ack[0]), 0);
        wake_req[0] = 1'b1;
        tick();
        check("fresh_req_ack", 32'(wake_ack[0]), 1);
        wake_req[0] = 1'b0;

        // Ch1 rescued from DRAIN by busy.
        busy[1] = 1'b1;
        repeat (WAKE_LAT + 1) tick();
        busy[1] = 1'b0;
        repeat (4) tick();
        check("model_in_drain", 32'(m_drain[1]), 1);
        busy[1] = 1'b1;
        tick();
        busy[1] = 1'b0;
        check("drain_rescue_on", 32'(ch_on[1]), 1);
        check("drain_rescue_no_ack", 32'(wake_ack[1]), 0);
        repeat (4) begin
            tick();
            check("rescued_stays_on", 32'(ch_on[1]), 1);
        end
        tick();
        check("rescued_then_off", 32'(ch_on[1]), 0);

        // idle_limit=0 keeps everything on; a low limit then gates at once.
        idle_limit = 8'd0;
        force_on = '1;
        repeat (WAKE_LAT + 2) tick();
        force_on = '0;
        repeat (300) tick();
        check("limit0_all_on", ch_on, 4'hF);
        idle_limit = 8'd3;
        tick();
        check("lowered_limit_drain", ch_on, 4'hF);
        tick();
        check("lowered_limit_off", ch_on, 4'h0);

        // Scan overrides the gate only.
        scan_enable = 1'b1;
        @(posedge clk);
        #2;
        check("scan_gclk_on", gclk, 4'hF);
        check("scan_fsm_off", ch_on, 4'h0);
        tick();
        scan_enable = 1'b0;
        @(posedge clk);
        #2;
        check("scan_off_parked", gclk, 4'h0);

        // Reset during WAKE on ch2 with a held request.
        tick();
        wake_req[2] = 1'b1;
        tick();
        check("ch2_waking", 32'(ch_on[2]), 1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_wake_on", ch_on, 4'hF);
        check("rst_mid_wake_no_ack", wake_ack, 0);
        tick();
        rst = 1'b0;
        tick();
        check("ack_after_reset", 32'(wake_ack[2]), 1);
        wake_req[2] = 1'b0;

        // Random traffic.
        idle_limit = 8'd2;
        repeat (3000) begin
            tick();
            for (int c = 0; c < NR_CH; c++) begin
                busy[c]     = ($urandom_range(0, 7) == 0);
                force_on[c] = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 11) == 0) wake_req[c] = ~wake_req[c];
            end
            if ($urandom_range(0, 30) == 0) scan_enable = ~scan_enable;
            if ($urandom_range(0, 100) == 0) idle_limit = IDLE_W'($urandom_range(0, 6));
            if ($urandom_range(0, 400) == 0) begin
                #1;
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
